// File: rtl/trig_multi_if.sv
// ---------------------------------------------------------------------------
// trig_multi_if -- configuration bus for the multi-channel trigger unit.
//
// Signals (driven by the master, consumed by the trigger unit):
//   wEN      configuration write strobe
//   wSEL     0 = channel CMD write, 1 = global write
//   wADDR    channel index for channel writes (AW bits)
//   wCMD     channel: [3] enable, [1:0] pattern; global: [0] mode (0 AND, 1 OR)
//   wDATA    global write: occurrence target (CNTW bits)
//   SetInit  clear all configuration
// ---------------------------------------------------------------------------
interface trig_multi_if #(
    parameter int AW   = 3,
    parameter int CNTW = 16
);
    logic            wEN;
    logic            wSEL;
    logic [AW-1:0]   wADDR;
    logic [3:0]      wCMD;
    logic [CNTW-1:0] wDATA;
    logic            SetInit;

    modport master (output wEN, wSEL, wADDR, wCMD, wDATA, SetInit);
    modport slave  (input  wEN, wSEL, wADDR, wCMD, wDATA, SetInit);
endinterface

// File: rtl/trig_multi.sv
// ---------------------------------------------------------------------------
// trig_multi -- parametrised multi-channel trigger unit.
//
// Each probe channel keeps a 2-sample history {prev, cur} and matches it
// against a per-channel pattern (00 low, 11 high, 01 rising, 10 falling).
// Channel results are combined in AND or OR mode; an IDLE/ARMED/FIRED state
// machine turns the combined match into a held flag and a one-cycle pulse.
//
// Optional feature: define TRIG_CNT_EN to fire on the Nth match (occurrence
// counter + target loaded by a global write). Without it the first match
// while armed fires and wDATA is ignored.
//
// Ports:
//   CLK        clock, rising edge
//   RSTn       asynchronous active-low reset
//   cfg        configuration bus (trig_multi_if.slave)
//   Xin[CH]    probe inputs, synchronous to CLK
//   EN         arm request (1 armed, 0 disarm / return to IDLE)
//   ResTri     trigger flag, high while FIRED
//   TrigPulse  one-cycle pulse on entry to FIRED
//   Armed      high while ARMED
// ---------------------------------------------------------------------------
module trig_multi #(
    parameter int CH   = 8,
    parameter int AW   = 3,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RSTn,
    trig_multi_if.slave     cfg,
    input  logic [CH-1:0]   Xin,
    input  logic            EN,
    output logic            ResTri,
    output logic            TrigPulse,
    output logic            Armed
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    logic [1:0]         state, stateNext;
    logic [CH-1:0][1:0] XinReg;      // [1] previous sample, [0] current sample
    logic [1:0]         fillCnt;     // samples taken since reset, saturates at 2
    logic [CH-1:0]      cmdEn;
    logic [CH-1:0][1:0] cmdPat;
    logic               modeOr;
    logic [CH-1:0]      chanRes;
    logic               hit;
    logic               fireOk;
    logic               unusedCfg;

    // -----------------------------------------------------------------------
    // Channel history and fill counter: shift in every cycle, in all states.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values, independent of always-block ordering.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            XinReg  <= '0;
            fillCnt <= '0;
        end else begin
            for (int c = 0; c < CH; c++)
                XinReg[c] <= {XinReg[c][0], Xin[c]};
            if (fillCnt != 2'd2)
                fillCnt <= fillCnt + 2'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Configuration registers. A write strobe wins over SetInit; channel
    // writes to an index >= CH match no channel and are dropped.
    // -----------------------------------------------------------------------
`ifdef TRIG_CNT_EN
    logic [CNTW-1:0] occTarget;
`endif

    // NOTE: this is a small flop-based register file, not a RAM, so it is
    // cleared by the asynchronous reset like any other state.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cmdEn     <= '0;
            cmdPat    <= '0;
            modeOr    <= 1'b0;
`ifdef TRIG_CNT_EN
            occTarget <= '0;
`endif
        end else if (cfg.wEN) begin
            if (!cfg.wSEL) begin
                for (int c = 0; c < CH; c++) begin
                    if (cfg.wADDR == AW'(c)) begin
                        cmdEn[c]  <= cfg.wCMD[3];
                        cmdPat[c] <= cfg.wCMD[1:0];
                    end
                end
            end else begin
                modeOr    <= cfg.wCMD[0];
`ifdef TRIG_CNT_EN
                occTarget <= cfg.wDATA;
`endif
            end
        end else if (cfg.SetInit) begin
            cmdEn     <= '0;
            cmdPat    <= '0;
            modeOr    <= 1'b0;
`ifdef TRIG_CNT_EN
            occTarget <= CNTW'(1);
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Combined match. A disabled channel is the identity of the reduction:
    // 1 for AND, 0 for OR.
    // -----------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        chanRes = '0;
        for (int c = 0; c < CH; c++)
            chanRes[c] = cmdEn[c] ? (XinReg[c] == cmdPat[c]) : !modeOr;
        hit = (fillCnt == 2'd2) && (modeOr ? |chanRes : &chanRes);
    end

    // -----------------------------------------------------------------------
    // Fire qualification.
    // -----------------------------------------------------------------------
`ifdef TRIG_CNT_EN
    logic [CNTW-1:0] occCnt, cntNext, effTarget;

    assign cntNext   = (&occCnt) ? occCnt : occCnt + CNTW'(1);
    assign effTarget = (occTarget == '0) ? CNTW'(1) : occTarget;
    // Fire on the hit that brings the count up to the target.
    assign fireOk    = hit && (cntNext == effTarget);
    assign unusedCfg = cfg.wCMD[2];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            occCnt <= '0;
        else if (state == ST_IDLE)
            occCnt <= '0;
        else if (state == ST_ARMED && EN && hit)
            occCnt <= cntNext;
    end
`else
    assign fireOk    = hit;
    assign unusedCfg = cfg.wCMD[2] ^ (^cfg.wDATA);
`endif

    // -----------------------------------------------------------------------
    // Armed/fired state machine. Dropping EN always wins over a hit.
    // -----------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:  if (EN) stateNext = ST_ARMED;
            ST_ARMED: begin
                if (!EN)         stateNext = ST_IDLE;
                else if (fireOk) stateNext = ST_FIRED;
            end
            ST_FIRED: if (!EN) stateNext = ST_IDLE;
            default:  stateNext = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are true flops that
    // line up with the state register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= ST_IDLE;
            ResTri    <= 1'b0;
            TrigPulse <= 1'b0;
            Armed     <= 1'b0;
        end else begin
            state     <= stateNext;
            ResTri    <= (stateNext == ST_FIRED);
            Armed     <= (stateNext == ST_ARMED);
            TrigPulse <= (state == ST_ARMED) && (stateNext == ST_FIRED);
        end
    end

endmodule

// File: tb/tb_trig_multi.sv
// ---------------------------------------------------------------------------
// tb_trig_multi -- self-checking bench for trig_multi.
// Directed scenarios check fixed expectations; a randomized run compares the
// outputs each cycle against a behavioural model of the trigger rules.
// ---------------------------------------------------------------------------
module tb_trig_multi;
    localparam int CH   = 8;
    localparam int AW   = 3;
    localparam int CNTW = 16;

    logic          CLK = 1'b0;
    logic          RSTn;
    logic [CH-1:0] Xin;
    logic          EN;
    logic          ResTri, TrigPulse, Armed;

    int nCompared   = 0;
    int nMismatched = 0;

    trig_multi_if #(.AW(AW), .CNTW(CNTW)) cfg ();

    trig_multi #(.CH(CH), .AW(AW), .CNTW(CNTW)) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .cfg       (cfg),
        .Xin       (Xin),
        .EN        (EN),
        .ResTri    (ResTri),
        .TrigPulse (TrigPulse),
        .Armed     (Armed)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural reference model ----------------
    bit mPrev[CH];
    bit mCur[CH];
    bit mEn[CH];
    int mPat[CH];
    int mSamples;
    bit mOr;
    int mTarget;
    int mCount;
    bit mArmed, mFired, mPulse;

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            mPrev[c] = 0; mCur[c] = 0; mEn[c] = 0; mPat[c] = 0;
        end
        mSamples = 0; mOr = 0; mTarget = 0; mCount = 0;
        mArmed = 0; mFired = 0; mPulse = 0;
    endfunction

    // Applies one rising edge using the inputs currently driven.
    function automatic void model_edge();
        bit anyM, allM, h, fire;
        int eff;
        anyM = 0; allM = 1;
        for (int c = 0; c < CH; c++) begin
            if (mEn[c]) begin
                if (mPat[c] == 2 * mPrev[c] + mCur[c]) anyM = 1;
                else allM = 0;
            end
        end
        h = (mSamples >= 2) && (mOr ? anyM : allM);
        mPulse = 0;
        if (mFired) begin
            if (!EN) mFired = 0;
        end else if (mArmed) begin
            if (!EN) mArmed = 0;
            else if (h) begin
`ifdef TRIG_CNT_EN
                if (mCount < (1 << CNTW) - 1) mCount++;
                eff  = (mTarget == 0) ? 1 : mTarget;
                fire = (mCount == eff);
`else
                eff  = 1;
                fire = (eff == 1);
`endif
                if (fire) begin
                    mArmed = 0; mFired = 1; mPulse = 1;
                end
            end
        end else if (EN) begin
            mArmed = 1; mCount = 0;
        end
        if (cfg.wEN) begin
            if (!cfg.wSEL) begin
                if (int'(cfg.wADDR) < CH) begin
                    mEn[int'(cfg.wADDR)]  = cfg.wCMD[3];
                    mPat[int'(cfg.wADDR)] = int'(cfg.wCMD[1:0]);
                end
            end else begin
                mOr     = cfg.wCMD[0];
                mTarget = int'(cfg.wDATA);
            end
        end else if (cfg.SetInit) begin
            for (int c = 0; c < CH; c++) begin
                mEn[c] = 0; mPat[c] = 0;
            end
            mOr = 0; mTarget = 1;
        end
        for (int c = 0; c < CH; c++) begin
            mPrev[c] = mCur[c];
            mCur[c]  = Xin[c];
        end
        if (mSamples < 2) mSamples++;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input bit sel, input int addr, input logic [3:0] cmd, input int data);
        cfg.wEN   = 1'b1;
        cfg.wSEL  = sel;
        cfg.wADDR = AW'(addr);
        cfg.wCMD  = cmd;
        cfg.wDATA = CNTW'(data);
        step();
        cfg.wEN   = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RSTn = 1'b0;
        Xin = '0; EN = 1'b0; cfg.wEN = 1'b0; cfg.SetInit = 1'b0;
        model_reset();
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RSTn = 1'b0;
        Xin = '0; EN = 1'b0;
        cfg.wEN = 1'b0; cfg.wSEL = 1'b0; cfg.wADDR = '0; cfg.wCMD = '0; cfg.wDATA = '0; cfg.SetInit = 1'b0;
        model_reset();
        #3;
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b000) begin
            nMismatched++;
            $display("FAIL reset_outputs: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b000);
        end
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        step();
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b000) begin
            nMismatched++;
            $display("FAIL reset_idle_no_en: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b000);
        end
    endtask

    task automatic test_and_all_disabled();
        do_reset();
        cfg.SetInit = 1'b1;
        step();                         // edge 1
        cfg.SetInit = 1'b0;
        step();                         // edge 2
        EN = 1'b1;
        step();                         // edge 3
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b001) begin
            nMismatched++;
            $display("FAIL and_dis_armed: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b001);
        end
        step();                         // edge 4
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b110) begin
            nMismatched++;
            $display("FAIL and_dis_fire: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b110);
        end
        step();                         // edge 5
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b100) begin
            nMismatched++;
            $display("FAIL and_dis_pulse_end: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b100);
        end
        EN = 1'b0;
        step();
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b000) begin
            nMismatched++;
            $display("FAIL and_dis_disarm: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b000);
        end
    endtask

    task automatic test_and_levels();
        Xin = '0;
        cfg_write(1'b0, 0, 4'b1001, 0);
        cfg_write(1'b0, 2, 4'b1011, 0);
        cfg_write(1'b1, 0, 4'b0000, 1);
        step();
        step();
        EN = 1'b1;
        step();
        Xin[0] = 1'b1;                  // ch0 rises with ch2 low
        step();
        step();
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b001) begin
            nMismatched++;
            $display("FAIL and_lvl_ch2_low: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b001);
        end
        Xin[0] = 1'b0;
        step();
        step();
        Xin[2] = 1'b1;
        step();
        step();
        Xin[0] = 1'b1;                  // ch0 rises with ch2 high: edge k
        step();
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b001) begin
            nMismatched++;
            $display("FAIL and_lvl_edge_k: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b001);
        end
        step();                         // edge k+1
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b110) begin
            nMismatched++;
            $display("FAIL and_lvl_fire: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b110);
        end
        EN = 1'b0;
        Xin = '0;
        step();
        step();
    endtask

    task automatic test_or_edges();
        Xin = '0;
        cfg.SetInit = 1'b1;
        step();
        cfg.SetInit = 1'b0;
        cfg_write(1'b0, 1, 4'b1010, 0);
        cfg_write(1'b0, 5, 4'b1001, 0);
        cfg_write(1'b1, 0, 4'b0001, 1);
        step();
        step();
        EN = 1'b1;
        step();
        Xin[3] = 1'b1;
        step();
        step();
        Xin[3] = 1'b0;
        step();
        step();
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b001) begin
            nMismatched++;
            $display("FAIL or_ch3_ignored: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b001);
        end
        Xin[5] = 1'b1;
        step();
        step();
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b110) begin
            nMismatched++;
            $display("FAIL or_ch5_fire: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b110);
        end
        EN = 1'b0;
        Xin = '0;
        step();
        step();
    endtask

    task automatic test_simul_disarm();
        cfg.SetInit = 1'b1;
        step();
        cfg.SetInit = 1'b0;
        step();
        EN = 1'b1;
        step();
        EN = 1'b0;                      // qualifying hit on this edge
        step();
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b000) begin
            nMismatched++;
            $display("FAIL simul_disarm: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b000);
        end
        EN = 1'b1;                      // re-arm after a one-cycle drop
        step();
        step();
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b110) begin
            nMismatched++;
            $display("FAIL rearm_fire: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b110);
        end
        EN = 1'b0;
        step();
    endtask

`ifdef TRIG_CNT_EN
    task automatic test_count();
        logic [2:0] want;
        Xin = '0;
        cfg.SetInit = 1'b1;
        step();
        cfg.SetInit = 1'b0;
        cfg_write(1'b0, 0, 4'b1001, 0);
        cfg_write(1'b1, 0, 4'b0000, 3);
        step();
        step();
        EN = 1'b1;
        step();
        for (int p = 1; p <= 3; p++) begin
            Xin[0] = 1'b1;
            step();
            Xin[0] = 1'b0;
            step();
            want = (p == 3) ? 3'b110 : 3'b001;
            nCompared++;
            if ({ResTri, TrigPulse, Armed} !== want) begin
                nMismatched++;
                $display("FAIL count3_pulse%0d: got %b want %b", p, {ResTri, TrigPulse, Armed}, want);
            end
        end
        EN = 1'b0;
        step();
        cfg_write(1'b1, 0, 4'b0000, 0);
        EN = 1'b1;
        step();
        Xin[0] = 1'b1;
        step();
        Xin[0] = 1'b0;
        step();
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b110) begin
            nMismatched++;
            $display("FAIL count0_first: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b110);
        end
        EN = 1'b0;
        step();
    endtask
`else
    task automatic test_first_hit();
        Xin = '0;
        cfg.SetInit = 1'b1;
        step();
        cfg.SetInit = 1'b0;
        cfg_write(1'b0, 0, 4'b1001, 0);
        cfg_write(1'b1, 0, 4'b0000, 3);   // wDATA has no effect here
        step();
        step();
        EN = 1'b1;
        step();
        Xin[0] = 1'b1;
        step();
        Xin[0] = 1'b0;
        step();
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b110) begin
            nMismatched++;
            $display("FAIL first_hit_fire: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b110);
        end
        EN = 1'b0;
        step();
    endtask
`endif

    task automatic test_reset_mid();
        Xin = '0;
        cfg.SetInit = 1'b1;
        step();
        cfg.SetInit = 1'b0;
        EN = 1'b1;
        step();
        step();
        nCompared++;
        if (ResTri !== 1'b1) begin
            nMismatched++;
            $display("FAIL rst_mid_pre_fired: got %b want %b", ResTri, 1'b1);
        end
        #2;
        RSTn = 1'b0;
        model_reset();
        #1;
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b000) begin
            nMismatched++;
            $display("FAIL rst_mid_immediate: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b000);
        end
        @(posedge CLK);
        #2;
        RSTn = 1'b1;                    // EN still high, config back to AND/all-disabled
        step();                         // edge 1
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b001) begin
            nMismatched++;
            $display("FAIL rst_rel_edge1: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b001);
        end
        step();                         // edge 2
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b001) begin
            nMismatched++;
            $display("FAIL rst_rel_edge2: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b001);
        end
        step();                         // edge 3
        nCompared++;
        if ({ResTri, TrigPulse, Armed} !== 3'b110) begin
            nMismatched++;
            $display("FAIL rst_rel_edge3: got %b want %b", {ResTri, TrigPulse, Armed}, 3'b110);
        end
        EN = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [2:0] want;
        EN = 1'b1;
        for (int i = 0; i < 400; i++) begin
            Xin         = CH'($urandom);
            if ($urandom_range(0, 9) == 0) EN = ~EN;
            cfg.wEN     = ($urandom_range(0, 7) == 0);
            cfg.wSEL    = 1'($urandom);
            cfg.wADDR   = AW'($urandom);
            cfg.wCMD    = 4'($urandom);
            cfg.wDATA   = CNTW'($urandom_range(0, 3));
            cfg.SetInit = ($urandom_range(0, 19) == 0);
            step();
            want = {mFired, mPulse, mArmed};
            nCompared++;
            if ({ResTri, TrigPulse, Armed} !== want) begin
                nMismatched++;
                $display("FAIL random_cycle%0d: got %b want %b", i, {ResTri, TrigPulse, Armed}, want);
            end
        end
        cfg.wEN = 1'b0;
        cfg.SetInit = 1'b0;
        EN = 1'b0;
    endtask

    initial begin
        test_reset();
        test_and_all_disabled();
        test_and_levels();
        test_or_edges();
        test_simul_disarm();
`ifdef TRIG_CNT_EN
        test_count();
`else
        test_first_hit();
`endif
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/trig_multi.md
# trig_multi

Parametrised multi-channel trigger unit for the logic analyzer capture path. It samples `CH` probe inputs on every `CLK` rising edge and evaluates a per-channel level/edge condition on each. The channel results are combined in AND or OR mode, and an armed/fired state machine drives a held trigger flag and a one-cycle trigger pulse to the capture controller. Occurrence counting (fire on the Nth match) is an optional compile-time feature.

## Interface
- `CH`, 8, number of probe channels (1..32).
- `AW`, 3, channel address width; must satisfy 2^AW >= CH.
- `CNTW`, 16, occurrence counter / target width.

- `CLK` in 1: sole clock; all state updates on the rising edge.
- `RSTn` in 1: asynchronous, active-low reset.
- `Xin` in CH: probe inputs, already synchronous to `CLK`.
- `EN` in 1: arm request; 1 = armed, 0 = disarm and return to IDLE.
- `wEN` in 1: configuration write strobe.
- `wSEL` in 1: 0 = channel CMD write, 1 = global write.
- `wADDR` in AW: channel index for channel writes; writes with `wADDR` >= CH are ignored.
- `wCMD` in 4: channel write uses `[3]` enable and `[1:0]` pattern; global write uses `[0]` mode (0 AND, 1 OR).
- `wDATA` in CNTW: global write, occurrence target.
- `SetInit` in 1: clear all configuration.
- `ResTri` out 1: trigger flag, held while FIRED.
- `TrigPulse` out 1: one-cycle pulse on entry to FIRED.
- `Armed` out 1: high in ARMED.

## Operation
- **Channel history:** `XinReg[c][1:0]` shifts `{prev, Xin[c]}` every cycle, in all states. Reset value is 0.
- **Fill counter:** a 2-bit fill counter is cleared by reset and saturates at 2. Matches are forced to 0 until it reaches 2.
- **Channel match:** an enabled channel matches when `XinReg[c] == CMD[c][1:0]`.
  - 00 low, 11 high, 01 rising, 10 falling.
- **Disabled channels:** a disabled channel contributes 1 in AND mode and 0 in OR mode.
  - AND with all channels disabled matches every cycle.
  - OR with all channels disabled never matches.
- **Combined match:** `hit` is the AND or OR of all channel results, computed combinationally from `XinReg` and configuration.
- **Configuration priority:** `wEN` has priority over `SetInit`.
  - `SetInit` clears all `CMD` to 0 and mode to AND; under `TRIG_CNT_EN` it sets the target to 1.
  - Configuration writes are accepted in any state and take effect on the following cycle's evaluation.
  - `SetInit` does not change FSM state.
- **FSM:** states IDLE, ARMED, FIRED; reset to IDLE.
  - IDLE → ARMED when `EN`=1. Clears the occurrence counter.
  - ARMED → FIRED on a qualifying `hit` (see Configuration). Asserts `TrigPulse` for that cycle.
  - ARMED → IDLE when `EN`=0. `EN`=0 has priority over a simultaneous `hit`.
  - FIRED holds until `EN`=0, then → IDLE. Further hits are ignored.
- **Outputs:**
  - `ResTri` is 1 exactly when in FIRED.
  - `Armed` is 1 exactly when in ARMED.
  - All outputs are registered and reset to 0.

## Timing
- **Trigger latency:** `Xin` sampled at edge k; `hit` is valid after edge k; `ResTri`/`TrigPulse` rise after edge k+1.
- **Arming latency:** `EN` rising at edge k enters ARMED at edge k. The first hit is evaluated on history after edge k, so the earliest fire is edge k+1.
- **Reset release:** after `RSTn` deasserts, the first possible `hit` uses history after the 2nd sampling edge.
- **Asynchronous reset:** `RSTn` low forces IDLE, clears history, configuration, counter and outputs immediately. This applies mid-operation too.
- **Pulse width:** `TrigPulse` is high for exactly one cycle per FIRED entry.
- **Re-arm:** dropping `EN` for one cycle re-arms cleanly on its return.

## Configuration
- **Macro:** `TRIG_CNT_EN`.
- **Defined:**
  - A CNTW-bit occurrence counter increments on each `hit` in ARMED.
  - The FSM fires on the hit that makes count equal the target. A target of 0 is treated as 1.
  - The counter saturates at all-ones.
  - A global write loads the target from `wDATA`.
- **Undefined:**
  - The first `hit` in ARMED fires.
  - `wDATA` is ignored and no counter or target registers exist.

## Test plan
- **AND with all disabled:** after reset, `SetInit`, `EN`=1 at edge 3 → `ResTri`=1 and `TrigPulse`=1 after edge 4; `TrigPulse`=0 after edge 5.
- **AND of levels:** ch0 rising (`CMD`=4'b1001) AND ch2 high (`CMD`=4'b1011); drive ch2=1, then ch0 0→1 sampled at edge k → `ResTri` rises after k+1. Ch0 rising with ch2=0 → no fire.
- **OR of edges:** OR mode, ch1 falling, ch5 rising; toggle only ch5 0→1 → fire. Toggle ch3 only → `Armed` stays 1, no fire.
- **Simultaneous disarm:** `EN`=0 in the same cycle as a qualifying hit → IDLE, `ResTri`=0, no `TrigPulse`.
- **Occurrence count (`TRIG_CNT_EN`):** target=3, ch0 rising, three pulses → fires after the 3rd edge + 1 cycle. Target=0 → fires on the 1st pulse.
- **Reset mid-operation:** `RSTn` low while FIRED → `ResTri`=0 immediately. After release, `EN`=1 with AND/all-disabled → no hit until 2 samples taken.
